// File: rtl/rr_burst_arbiter.sv
// Round-robin burst arbiter: grants one requester a shared beat resource until it drops req, hits its burst limit or stalls.
// Latency: req to gnt is 1 cycle; hand-off between owners has no bubble. Backpressure: beat_done is the only progress signal.
module rr_burst_arbiter #(
    parameter int N       = 8,
    parameter int ID_W    = 3,
    parameter int BURST_W = 4,
    parameter int TIMEOUT = 255,
    parameter int TMO_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       req,
    input  logic               beat_done,
    input  logic [BURST_W-1:0] max_burst,
    output logic [N-1:0]       gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               busy,
    output logic               release_p,
    output logic               timeout_err
);
    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);
    localparam logic [TMO_W-1:0]   TMO_ONE   = TMO_W'(1);
    localparam logic [ID_W-1:0]    ID_ONE    = ID_W'(1);
    localparam logic [ID_W-1:0]    ID_LAST   = ID_W'(N - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t             state;
    logic [ID_W-1:0]    ptr;
    logic [BURST_W-1:0] beat_cnt;
    logic [BURST_W-1:0] limit;
    logic [TMO_W-1:0]   tmo_cnt;

    // Returns {found, index} of the first set request scanning upward from base, wrapping.
    function automatic logic [ID_W:0] pick(input logic [N-1:0] r, input logic [ID_W-1:0] base);
        logic            found;
        logic [ID_W-1:0] idx;
        int              j;
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j = (int'(base) + i) % N;
            if (r[ID_W'(j)]) begin
                found = 1'b1;
                idx   = ID_W'(j);
            end
        end
        return {found, idx};
    endfunction

    logic            own_req;
    logic            burst_end;
    logic            wd_end;
    logic            rel;
    logic            rel_tmo;
    logic [ID_W-1:0] next_ptr;
    logic [ID_W-1:0] base;
    logic [ID_W:0]   arb;
    logic            win_vld;
    logic [ID_W-1:0] win_id;
    logic            load;

    assign own_req   = req[gnt_id];
    // beat_cnt never reaches a nonzero limit, so limit-1 cannot underflow here.
    assign burst_end = beat_done && (limit != '0) && (beat_cnt == limit - BURST_ONE);
    assign wd_end    = (TIMEOUT != 0) && !beat_done && (tmo_cnt == TMO_LAST);
    assign rel       = (state == GRANT) && (!own_req || burst_end || wd_end);
    assign rel_tmo   = own_req && !burst_end && wd_end;
    assign next_ptr  = (gnt_id == ID_LAST) ? '0 : gnt_id + ID_ONE;

    // On release the scan starts just past the old owner, leaving it lowest priority.
    assign base    = (state == GRANT) ? next_ptr : ptr;
    assign arb     = pick(req, base);
    assign win_vld = arb[ID_W];
    assign win_id  = arb[ID_W-1:0];
    assign load    = win_vld && ((state == IDLE) || rel);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            beat_cnt    <= '0;
            limit       <= '0;
            tmo_cnt     <= '0;
            gnt         <= '0;
            gnt_id      <= '0;
            busy        <= 1'b0;
            release_p   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            release_p   <= rel;
            timeout_err <= rel && rel_tmo;
            if (rel) begin
                ptr <= next_ptr;
            end

            if (load) begin
                state    <= GRANT;
                gnt      <= N'(1) << win_id;
                gnt_id   <= win_id;
                busy     <= 1'b1;
                beat_cnt <= '0;
                tmo_cnt  <= '0;
                limit    <= max_burst;
            end else if (rel) begin
                state <= IDLE;
                gnt   <= '0;
                busy  <= 1'b0;
            end else if (state == GRANT) begin
                if (beat_done) begin
                    // With an unlimited burst the count only saturates; nothing reads it.
                    if ((limit != '0) || (beat_cnt != '1)) begin
                        beat_cnt <= beat_cnt + BURST_ONE;
                    end
                    tmo_cnt <= '0;
                end else if (TIMEOUT != 0) begin
                    tmo_cnt <= tmo_cnt + TMO_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Directed bench for rr_burst_arbiter: a queue-free behavioural model checked every cycle plus literal spot checks.
module tb_rr_burst_arbiter;
    localparam int N   = 8;
    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       beat_done;
    logic [3:0] max_burst;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       busy;
    logic       release_p;
    logic       timeout_err;

    logic [7:0] req_b;
    logic       bd_b;
    logic [3:0] mb_b;
    logic [7:0] gnt_b;
    logic [2:0] gnt_id_b;
    logic       busy_b;
    logic       release_p_b;
    logic       timeout_err_b;

    always #5 clk = ~clk;

    rr_burst_arbiter #(.N(8), .ID_W(3), .BURST_W(4), .TIMEOUT(TMO), .TMO_W(8)) dut (
        .clk(clk), .rst(rst), .req(req), .beat_done(beat_done), .max_burst(max_burst),
        .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .release_p(release_p), .timeout_err(timeout_err)
    );

    rr_burst_arbiter #(.N(8), .ID_W(3), .BURST_W(4), .TIMEOUT(0), .TMO_W(8)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .beat_done(bd_b), .max_burst(mb_b),
        .gnt(gnt_b), .gnt_id(gnt_id_b), .busy(busy_b), .release_p(release_p_b), .timeout_err(timeout_err_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: who owns the resource, where the scan starts, beats and stall cycles so far.
    int m_own, m_ptr, m_beats, m_idle, m_lim;
    bit m_busy, m_rel, m_tmo;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit bit_of(input logic [7:0] r, input int k);
        return ((r >> k) & 8'd1) != 8'd0;
    endfunction

    function automatic int first_from(input logic [7:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            if (bit_of(r, (p + i) % N)) return (p + i) % N;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_own = 0; m_ptr = 0; m_beats = 0; m_idle = 0; m_lim = 0;
        m_busy = 0; m_rel = 0; m_tmo = 0;
    endfunction

    function automatic void grant_to(input int w);
        m_own = w; m_busy = 1; m_beats = 0; m_idle = 0; m_lim = int'(max_burst);
    endfunction

    function automatic void model_tick();
        int w;
        bit rel, tmo;
        rel = 0;
        tmo = 0;
        if (rst) begin
            model_reset();
            return;
        end
        if (!m_busy) begin
            w = first_from(req, m_ptr);
            if (w >= 0) grant_to(w);
        end else begin
            if (!bit_of(req, m_own)) rel = 1;
            else if (beat_done && m_lim != 0 && m_beats + 1 == m_lim) rel = 1;
            else if (TMO != 0 && !beat_done && m_idle == TMO - 1) begin
                rel = 1;
                tmo = 1;
            end
            if (rel) begin
                m_ptr = (m_own + 1) % N;
                w = first_from(req, m_ptr);
                if (w >= 0) grant_to(w);
                else m_busy = 0;
            end else if (beat_done) begin
                if (m_beats < 15) m_beats++;
                m_idle = 0;
            end else begin
                m_idle++;
            end
        end
        m_rel = rel;
        m_tmo = tmo;
    endfunction

    task automatic compare();
        chk("gnt", 32'(gnt), m_busy ? 32'(1 << m_own) : 32'd0);
        chk("busy", 32'(busy), 32'(m_busy));
        chk("release_p", 32'(release_p), 32'(m_rel));
        chk("timeout_err", 32'(timeout_err), 32'(m_tmo));
        if (m_busy) chk("gnt_id", 32'(gnt_id), 32'(m_own));
    endtask

    task automatic step();
        @(posedge clk);
        model_tick();
        @(negedge clk);
        compare();
    endtask

    task automatic drive(input logic [7:0] r, input logic bd, input logic [3:0] mb);
        req = r;
        beat_done = bd;
        max_burst = mb;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(8'h00, 1'b0, 4'd0);
        step();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation exceeded its time budget");
        $fatal(1, "time budget exceeded");
    end

    initial begin
        int bad;
        rst = 1'b1;
        drive(8'h00, 1'b0, 4'd0);
        req_b = 8'h00;
        bd_b = 1'b0;
        mb_b = 4'd0;
        model_reset();
        step();
        step();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_gnt_id", 32'(gnt_id), 32'h0);
        chk("rst_release_p", 32'(release_p), 32'h0);
        chk("rst_timeout_err", 32'(timeout_err), 32'h0);
        rst = 1'b0;

        // Reset mid-burst: owner 3 after two beats.
        drive(8'h08, 1'b0, 4'd0);
        step();
        chk("t1_gnt", 32'(gnt), 32'h08);
        drive(8'h08, 1'b1, 4'd0);
        step();
        step();
        drive(8'h08, 1'b0, 4'd0);
        @(posedge clk);
        model_tick();
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("t1_async_gnt", 32'(gnt), 32'h0);
        chk("t1_async_busy", 32'(busy), 32'h0);
        @(negedge clk);
        compare();
        rst = 1'b0;
        step();
        chk("t1_regrant", 32'(gnt), 32'h08);
        chk("t1_ptr", 32'(m_ptr), 32'd0);

        // Full rotation, two beats per grant.
        do_reset();
        drive(8'hFF, 1'b1, 4'd2);
        for (int k = 0; k < 18; k++) begin
            step();
            chk("rot_gnt", 32'(gnt), 32'(1 << ((k / 2) % 8)));
            chk("rot_release_p", 32'(release_p), 32'(k > 0 && k % 2 == 0));
        end

        // Early drop by owner 5 with ptr parked at 5.
        do_reset();
        drive(8'h10, 1'b0, 4'd0);
        step();
        chk("t3_gnt4", 32'(gnt), 32'h10);
        drive(8'h00, 1'b0, 4'd0);
        step();
        chk("t3_idle_busy", 32'(busy), 32'h0);
        chk("t3_idle_rel", 32'(release_p), 32'h1);
        chk("t3_ptr5", 32'(m_ptr), 32'd5);
        drive(8'h21, 1'b1, 4'd0);
        step();
        chk("t3_gnt5", 32'(gnt), 32'h20);
        step();
        step();
        step();
        drive(8'h01, 1'b1, 4'd0);
        step();
        chk("t3_drop_gnt", 32'(gnt), 32'h01);
        chk("t3_drop_rel", 32'(release_p), 32'h1);
        chk("t3_ptr6", 32'(m_ptr), 32'd6);

        // Sole requester keeps winning at each burst boundary.
        do_reset();
        drive(8'h10, 1'b1, 4'd3);
        for (int k = 0; k < 9; k++) begin
            step();
            chk("rewin_gnt", 32'(gnt), 32'h10);
            chk("rewin_release_p", 32'(release_p), 32'(k > 0 && k % 3 == 0));
        end
        chk("rewin_ptr", 32'(m_ptr), 32'd5);

        // Watchdog: owner 2 stalls for TMO cycles, hands off to 6.
        do_reset();
        drive(8'h44, 1'b0, 4'd0);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("wd_gnt", 32'(gnt), (k < 4) ? 32'h04 : 32'h40);
            chk("wd_timeout_err", 32'(timeout_err), 32'(k == 4));
        end

        // Watchdog disabled: grant survives 1000 stalled cycles.
        do_reset();
        req_b = 8'h02;
        step();
        chk("tmo0_gnt", 32'(gnt_b), 32'h02);
        bad = 0;
        for (int k = 0; k < 1000; k++) begin
            step();
            if (gnt_b !== 8'h02 || busy_b !== 1'b1 || release_p_b !== 1'b0 ||
                timeout_err_b !== 1'b0 || gnt_id_b !== 3'd1) bad++;
        end
        chk("tmo0_hold_cycles_bad", 32'(bad), 32'd0);
        req_b = 8'h00;
        step();
        chk("tmo0_drop_busy", 32'(busy_b), 32'h0);
        chk("tmo0_drop_rel", 32'(release_p_b), 32'h1);

        // Unlimited burst from ptr 7, then wrap to requester 0.
        do_reset();
        drive(8'h40, 1'b0, 4'd0);
        step();
        drive(8'h00, 1'b0, 4'd0);
        step();
        chk("t6_ptr7", 32'(m_ptr), 32'd7);
        drive(8'h81, 1'b1, 4'd0);
        for (int k = 0; k < 21; k++) begin
            step();
            chk("t6_hold_gnt", 32'(gnt), 32'h80);
        end
        drive(8'h01, 1'b1, 4'd0);
        step();
        chk("t6_wrap_gnt", 32'(gnt), 32'h01);
        chk("t6_wrap_rel", 32'(release_p), 32'h1);
        chk("t6_ptr0", 32'(m_ptr), 32'd0);

        drive(8'h00, 1'b0, 4'd0);
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_burst_arbiter.md
Name: rr_burst_arbiter

Overview:
- Round-robin arbiter that grants one of N requesters exclusive ownership of a shared beat-oriented resource for a multi-beat burst.
- Holds the grant until one of three release events: requester drops req, burst limit reached, or beat watchdog expires.
- Rotates priority past the released owner. Back-to-back hand-off with no bubble cycle.
- Sits between requester ports and the shared datapath's mux and handshake.

Parameters:
N, 8, number of requesters
ID_W, 3, width of gnt_id; must equal clog2(N)
BURST_W, 4, width of max_burst and internal beat counter
TIMEOUT, 255, cycles without beat_done before forced release; 0 disables the watchdog
TMO_W, 8, width of watchdog counter; TIMEOUT must be less than 2^TMO_W

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
req  input  N  request per requester; level, held while wanting ownership
beat_done  input  1  resource consumed one beat from the current owner this cycle
max_burst  input  BURST_W  beats per grant before forced rotation; 0 = unlimited; sampled when a grant is issued
gnt  output  N  registered one-hot grant, or all zero
gnt_id  output  ID_W  binary index of the owner; valid when busy=1
busy  output  1  1 while any grant is held
release_p  output  1  one-cycle pulse on the cycle after any grant release
timeout_err  output  1  one-cycle pulse on the cycle after a watchdog release

Behaviour:
- Reset (async, any time, including mid-burst):
  - gnt=0, gnt_id=0, busy=0, release_p=0, timeout_err=0.
  - ptr=0, beat_cnt=0, tmo_cnt=0, latched limit=0, state=IDLE.
- State IDLE (busy=0):
  - If req!=0, pick the first set bit scanning ptr, ptr+1, ..., wrapping modulo N.
  - Next edge: gnt=onehot(winner), gnt_id=winner, busy=1, beat_cnt=0, tmo_cnt=0, latch max_burst. Go to GRANT.
  - Latency: req rising to gnt is exactly 1 cycle.
  - beat_done is ignored in IDLE.
- State GRANT: release condition is evaluated every cycle, with priority:
  - R1: req[gnt_id]==0.
  - R2: beat_done=1 and latched limit!=0 and beat_cnt+1==limit.
  - R3: TIMEOUT!=0 and beat_done=0 and tmo_cnt==TIMEOUT-1.
- No release:
  - beat_done=1: beat_cnt+1, tmo_cnt cleared.
  - beat_done=0: tmo_cnt+1.
  - When limit=0, beat_cnt saturates at its maximum.
- On release at edge E:
  - ptr=(gnt_id+1) mod N.
  - Re-arbitrate the same cycle using the new ptr on current req, with req[gnt_id] included. The old owner is therefore lowest priority and may win again only if it is the sole requester.
  - If there is a winner: gnt switches directly to it, counters clear, max_burst is re-latched, state stays GRANT.
  - If req (after R1 masking) is 0: gnt=0, busy=0, go to IDLE.
  - release_p=1 for the cycle after E. timeout_err=1 for that cycle only if R3 caused the release.
- A beat_done coinciding with R1 is not counted and has no effect.
- gnt is never multi-hot. gnt changes only at a release or an IDLE grant.
- ptr updates only on release, never in IDLE.

Test Plan:
- Reset mid-burst: owner=3 at beat 2, assert rst -> same cycle gnt=0, busy=0; after deassert, req=8'h08 -> gnt=8'h08 one cycle later, ptr=0.
- Rotation: req=8'hFF held, max_burst=2, beat_done every cycle -> grants 0,1,2,...,7,0, each 2 cycles. No bubble. release_p pulses every 2 cycles.
- Early drop: owner 5, max_burst=0, req[5] drops after 3 beats with req=8'h21 -> next edge gnt=8'h01, ptr=6, release_p=1.
- Sole requester re-win: req=8'h10, max_burst=3 -> gnt stays 8'h10 across release; release_p pulses every 3 beats; ptr=5.
- Watchdog: TIMEOUT=4, owner 2, no beat_done for 4 cycles, req=8'h44 -> gnt=8'h40, timeout_err=1 one cycle. With TIMEOUT=0, grant holds for 1000 idle cycles.
- Unlimited burst + wrap: ptr=7, req=8'h81, max_burst=0, 20 beats -> gnt stays 8'h80 until req[7] drops, then gnt=8'h01, ptr=0.
